// File: rtl/fifo_uart_pkg.sv
// Shared types and width helpers for the FIFO-draining UART transmitter.
package fifo_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    START,
    DATA,
    STOP
  } state_t;

  // A one-bit counter is still needed when a bit is only two clocks long.
  function automatic int baud_cnt_w(input int cpb);
    return ($clog2(cpb) > 1) ? $clog2(cpb) : 1;
  endfunction

  function automatic int bit_cnt_w(input int dw);
    return $clog2(dw + 1);
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period down-counter: bit_tick marks the last clock of each serial bit.
module uart_bit_timer
  import fifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic bit_tick
);

  localparam int CW = baud_cnt_w(CLKS_PER_BIT);
  localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  // restart aligns a fresh full-length bit to the first cycle of a new state
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (restart || (cnt == '0)) begin
      cnt <= RELOAD;
    end else begin
      cnt <= cnt - CW'(1);
    end
  end

  assign bit_tick = (cnt == '0);

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops one FIFO word per frame and shifts it out as start + data (LSB first) + stop bits.
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  fifo_rd_en,
  output logic                  tx,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int BW = bit_cnt_w(DATA_WIDTH);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_WIDTH - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  state_t                  state;
  state_t                  state_next;
  logic [DATA_WIDTH-1:0]   shreg;
  logic [BW-1:0]           bit_cnt;
  logic                    bit_tick;
  logic                    restart;

  assign restart = (state_next != state);

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .bit_tick(bit_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (enable && !fifo_empty) state_next = FETCH;
      FETCH:   state_next = LOAD;
      LOAD:    state_next = START;
      START:   if (bit_tick) state_next = DATA;
      DATA:    if (bit_tick && (bit_cnt == LAST_DATA)) state_next = STOP;
      STOP:    if (bit_tick && (bit_cnt == LAST_STOP)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // bit_cnt counts data bits in DATA and stop bits in STOP
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else begin
      if (state == LOAD) begin
        shreg <= fifo_dout;
      end else if ((state == DATA) && bit_tick) begin
        shreg <= shreg >> 1;
      end
      if (restart) begin
        bit_cnt <= '0;
      end else if (bit_tick && ((state == DATA) || (state == STOP))) begin
        bit_cnt <= bit_cnt + BW'(1);
      end
    end
  end

  always_comb begin
    tx         = 1'b1;
    fifo_rd_en = 1'b0;
    busy       = (state != IDLE);
    frame_done = 1'b0;
    case (state)
      FETCH:   fifo_rd_en = 1'b1;
      START:   tx = 1'b0;
      DATA:    tx = shreg[0];
      STOP:    frame_done = bit_tick && (bit_cnt == LAST_STOP);
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Scoreboard bench for fifo_uart_tx: a FIFO model feeds two DUT configurations, a line monitor decodes frames.
module tb_fifo_uart_tx;
  import fifo_uart_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       sel = 1'b0;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_dout = 8'h00;

  logic rd_a, tx_a, busy_a, done_a;
  logic rd_b, tx_b, busy_b, done_b;
  logic en_a, en_b;
  logic m_rd, m_tx, m_busy, m_done;

  assign en_a   = enable & ~sel;
  assign en_b   = enable & sel;
  assign m_rd   = sel ? rd_b : rd_a;
  assign m_tx   = sel ? tx_b : tx_a;
  assign m_busy = sel ? busy_b : busy_a;
  assign m_done = sel ? done_b : done_a;

  fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(16), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst(rst), .enable(en_a), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
    .fifo_rd_en(rd_a), .tx(tx_a), .busy(busy_a), .frame_done(done_a)
  );

  fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .STOP_BITS(2)) dut_b (
    .clk(clk), .rst(rst), .enable(en_b), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
    .fifo_rd_en(rd_b), .tx(tx_b), .busy(busy_b), .frame_done(done_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  int pop_times[$];
  int start_times[$];
  int idle_cycles[$];
  int vec_cnt = 0;
  int miss_cnt = 0;
  int underflows = 0;

  // FIFO model with a registered empty flag and one-cycle read latency
  always @(posedge clk) begin
    if (m_rd) begin
      if (fifo_q.size() == 0) underflows++;
      else fifo_dout <= fifo_q.pop_front();
    end
    fifo_empty <= (fifo_q.size() == 0);
  end

  always @(negedge clk) begin
    if (m_rd) pop_times.push_back(cyc);
    if (!m_busy) idle_cycles.push_back(cyc);
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vec_cnt++;
    if (actual !== expected) begin
      miss_cnt++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] word, input bit will_send);
    fifo_q.push_back(word);
    if (will_send) exp_q.push_back(word);
  endtask

  task automatic waitIdle(input int bound, input string name);
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !m_busy) return;
    end
    checkOutput({name, "_timeout"}, 1, 0);
  endtask

  task automatic clearLogs();
    pop_times.delete();
    start_times.delete();
    idle_cycles.delete();
  endtask

  function automatic int firstIdleAfter(input int s);
    int best = -1;
    foreach (idle_cycles[i])
      if (idle_cycles[i] > s && (best < 0 || idle_cycles[i] < best)) best = idle_cycles[i];
    return best;
  endfunction

  // Line monitor: checks every cycle of a frame against the expected word
  int         mon_cpb, mon_flen, mon_errs, mon_done_pos, mon_done_hits, mon_b;
  logic [7:0] mon_exp, mon_got;
  logic       mon_expb;
  bit         mon_have, mon_abort;
  initial begin : frame_mon
    forever begin
      @(negedge clk);
      if (m_busy && m_tx == 1'b0) begin
        mon_cpb       = sel ? 4 : 16;
        mon_flen      = (1 + 8 + (sel ? 2 : 1)) * mon_cpb;
        mon_errs      = 0;
        mon_done_pos  = -1;
        mon_done_hits = 0;
        mon_got       = 8'h00;
        mon_abort     = 1'b0;
        mon_have      = (exp_q.size() > 0);
        mon_exp       = mon_have ? exp_q[0] : 8'h00;
        start_times.push_back(cyc);
        for (int k = 0; k < mon_flen; k++) begin
          if (k > 0) @(negedge clk);
          if (!m_busy) begin
            mon_abort = 1'b1;
            break;
          end
          mon_b = k / mon_cpb;
          if (mon_b == 0) mon_expb = 1'b0;
          else if (mon_b <= 8) mon_expb = mon_exp[mon_b-1];
          else mon_expb = 1'b1;
          if (m_tx !== mon_expb) mon_errs++;
          if (m_done) begin
            mon_done_hits++;
            mon_done_pos = k;
          end
          if ((k % mon_cpb) == (mon_cpb / 2) && mon_b >= 1 && mon_b <= 8) mon_got[mon_b-1] = m_tx;
        end
        if (!mon_abort) begin
          checkOutput("frame_expected", 32'(mon_have), 1);
          if (mon_have) void'(exp_q.pop_front());
          checkOutput("frame_word", 32'(mon_got), 32'(mon_exp));
          checkOutput("frame_wave_errs", mon_errs, 0);
          checkOutput("frame_done_pos", mon_done_pos, mon_flen - 1);
          checkOutput("frame_done_hits", mon_done_hits, 1);
        end
      end
    end
  end

  int t, r, s, idle_between, fi;

  initial begin
    // Reset and idle with an empty FIFO while enabled
    rst = 1'b1;
    enable = 1'b1;
    @(posedge clk);
    repeat (3) begin
      @(negedge clk);
      checkOutput("reset_outputs", 32'({m_tx, m_rd, m_busy, m_done}), 32'h8);
    end
    rst = 1'b0;
    repeat (100) begin
      @(negedge clk);
      checkOutput("idle_outputs", 32'({m_tx, m_rd, m_busy, m_done}), 32'h8);
    end
    checkOutput("idle_pops", pop_times.size(), 0);
    enable = 1'b0;

    // Single word 0xA5
    clearLogs();
    applyStimulus(8'hA5, 1'b1);
    repeat (2) @(negedge clk);
    enable = 1'b1;
    t = cyc;
    waitIdle(300, "single");
    repeat (3) @(negedge clk);
    checkOutput("single_pops", pop_times.size(), 1);
    if (pop_times.size() > 0) checkOutput("single_pop_time", pop_times[0], t + 1);
    if (start_times.size() > 0) checkOutput("single_start_time", start_times[0], t + 3);
    checkOutput("single_frame_end", firstIdleAfter(t + 3), t + 3 + 160);
    enable = 1'b0;

    // Drain three words back to back
    clearLogs();
    applyStimulus(8'h00, 1'b1);
    applyStimulus(8'hFF, 1'b1);
    applyStimulus(8'h3C, 1'b1);
    repeat (2) @(negedge clk);
    enable = 1'b1;
    waitIdle(800, "drain");
    repeat (5) @(negedge clk);
    checkOutput("drain_pops", pop_times.size(), 3);
    checkOutput("drain_starts", start_times.size(), 3);
    if (start_times.size() == 3) begin
      checkOutput("drain_period_1", start_times[1] - start_times[0], 163);
      checkOutput("drain_period_2", start_times[2] - start_times[1], 163);
    end
    if (pop_times.size() == 3) begin
      idle_between = 0;
      foreach (idle_cycles[i])
        if (idle_cycles[i] > pop_times[0] && idle_cycles[i] < pop_times[2]) idle_between++;
      checkOutput("drain_idle_gap", idle_between, 2);
    end
    enable = 1'b0;

    // enable dropped mid-DATA with two words queued
    clearLogs();
    applyStimulus(8'h11, 1'b1);
    applyStimulus(8'h22, 1'b0);
    repeat (2) @(negedge clk);
    enable = 1'b1;
    repeat (51) @(negedge clk);
    enable = 1'b0;
    waitIdle(300, "endrop");
    repeat (200) @(negedge clk);
    checkOutput("endrop_pops", pop_times.size(), 1);
    checkOutput("endrop_fifo_left", fifo_q.size(), 1);
    if (fifo_q.size() > 0) checkOutput("endrop_fifo_word", 32'(fifo_q[0]), 32'h22);
    fifo_q.delete();
    repeat (2) @(negedge clk);

    // Reset during the fifth data bit, then recover
    clearLogs();
    applyStimulus(8'hC3, 1'b0);
    repeat (2) @(negedge clk);
    enable = 1'b1;
    repeat (90) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_tx", 32'(m_tx), 1);
    checkOutput("rst_busy", 32'(m_busy), 0);
    checkOutput("rst_state", 32'(dut_a.state), 32'(IDLE));
    applyStimulus(8'h5A, 1'b1);
    repeat (2) @(negedge clk);
    clearLogs();
    rst = 1'b0;
    r = cyc;
    waitIdle(300, "rst_recover");
    repeat (3) @(negedge clk);
    checkOutput("rst_recover_pops", pop_times.size(), 1);
    if (pop_times.size() > 0) checkOutput("rst_recover_pop_time", pop_times[0], r + 1);
    if (start_times.size() > 0) checkOutput("rst_recover_start", start_times[0], r + 3);
    enable = 1'b0;

    // Two stop bits, four clocks per bit, word 0x81
    sel = 1'b1;
    repeat (2) @(negedge clk);
    clearLogs();
    applyStimulus(8'h81, 1'b1);
    repeat (2) @(negedge clk);
    enable = 1'b1;
    t = cyc;
    waitIdle(200, "stop2");
    repeat (3) @(negedge clk);
    checkOutput("stop2_pops", pop_times.size(), 1);
    if (start_times.size() > 0) begin
      s = start_times[0];
      fi = firstIdleAfter(s);
      checkOutput("stop2_start_time", s, t + 3);
      checkOutput("stop2_frame_len", fi - s, 44);
      checkOutput("stop2_stop_len", fi - (s + 9 * 4), 8);
    end else begin
      checkOutput("stop2_started", 0, 1);
    end
    enable = 1'b0;

    repeat (5) @(negedge clk);
    checkOutput("frames_pending", exp_q.size(), 0);
    checkOutput("underflows", underflows, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Read-side consumer for the team's synchronous FIFO: pops one word at a time through the FIFO's `rd_en`/`dout`/`empty` port and transmits it as an asynchronous serial frame. The frame is one start bit, DATA_WIDTH data bits LSB first, and STOP_BITS stop bits. It sits directly on the FIFO read port and drives the serial pin, draining the buffer whenever enabled.

## Interface
Parameters:
- DATA_WIDTH, 8, word width; matches the FIFO word width.
- CLKS_PER_BIT, 16, clock cycles per serial bit; must be ≥ 2.
- STOP_BITS, 1, number of stop bits; must be 1 or 2.

Ports:
- clk  in  1  single system clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- enable  in  1  permits starting a new frame; sampled only in IDLE.
- fifo_empty  in  1  FIFO empty flag.
- fifo_dout  in  DATA_WIDTH  FIFO read data; valid the cycle after a pop.
- fifo_rd_en  out  1  pop request to the FIFO; one-cycle pulse.
- tx  out  1  serial line; idle high.
- busy  out  1  high from FETCH through the last stop-bit cycle.
- frame_done  out  1  one-cycle pulse in the last stop-bit cycle.

## Operation
- Moore FSM states: IDLE, FETCH, LOAD, START, DATA, STOP.
- IDLE → FETCH when enable && !fifo_empty. Otherwise stay in IDLE.
- FETCH: fifo_rd_en = 1 for exactly this one cycle. The FSM always advances to LOAD.
- LOAD: capture fifo_dout into the shift register at the end of the cycle, then go to START.
- START: tx = 0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA: tx = shreg[0]. Every CLKS_PER_BIT cycles, shift right and increment the bit count. After DATA_WIDTH bits, go to STOP.
- STOP: tx = 1 for STOP_BITS*CLKS_PER_BIT cycles, then go to IDLE.
- Outside START and DATA, tx = 1.
- Baud counter: width $clog2(CLKS_PER_BIT). It clears on every state entry and on every bit boundary.
- Bit counter: width $clog2(DATA_WIDTH+1).
- Exactly one pop per frame. The block never pops while fifo_empty = 1. Back-to-back pops cannot occur, so the FIFO's registered empty flag never causes an underflow.
- enable deasserted mid-frame: the current frame completes, and no new FETCH starts.
- fifo_empty rising during a frame has no effect.
- Reset mid-frame: on the next edge the FSM is in IDLE and tx = 1. The popped word is discarded and no partial frame resumes.

## Timing
- Reset values: tx = 1, fifo_rd_en = 0, busy = 0, frame_done = 0, state = IDLE, both counters = 0.
- Let T be the cycle in which IDLE sees enable && !fifo_empty:
  - T+1: fifo_rd_en high.
  - T+2: LOAD; fifo_dout valid.
  - T+3: first start-bit cycle.
- Data bit i occupies cycles T+3+CLKS_PER_BIT*(1+i) through T+3+CLKS_PER_BIT*(2+i)−1.
- Frame length on the line: (1+DATA_WIDTH+STOP_BITS)*CLKS_PER_BIT cycles.
- frame_done: high in the final STOP cycle.
- Minimum gap between frames: IDLE + FETCH + LOAD = 3 high cycles. Continuous drain period = frame length + 3.
- All outputs are registered or decoded from state only. There are no combinational paths from inputs to outputs.

## Structure
- Package fifo_uart_pkg:
  - state enum (IDLE, FETCH, LOAD, START, DATA, STOP)
  - localparam helpers for counter widths
- One natural sub-module: uart_bit_timer. It holds the CLKS_PER_BIT down-counter, with a restart input and a bit_tick output; the FSM and shift register stay in the top.
- Expected RTL: top ~180 lines, timer ~50 lines, package ~20 lines.

## Test plan
- Reset then idle: rst = 1 for 3 cycles with fifo_empty = 1 → tx = 1, fifo_rd_en = 0, busy = 0 throughout, and no pop for 100 cycles.
- Single word: FIFO holds 0xA5, enable = 1, CLKS_PER_BIT = 16.
  - fifo_rd_en pulses exactly once.
  - tx shows start bit 0, then bits 1,0,1,0,0,1,0,1, then stop bit 1, each held 16 cycles.
  - frame_done fires 160 cycles after the start edge.
- Drain three words 0x00, 0xFF, 0x3C: exactly 3 pops, frames 163 cycles apart, and busy low for only 1 cycle (IDLE) between frames.
- enable dropped mid-DATA with 2 words queued: the current frame completes, no further pop occurs, and the second word remains in the FIFO.
- rst asserted in the 5th data bit: next cycle tx = 1 and state is IDLE; after release with a non-empty FIFO, the next pop follows the T+1 rule.
- STOP_BITS = 2, CLKS_PER_BIT = 4, word 0x81: stop interval is 8 cycles and total frame is 44 cycles; a checker confirms tx never glitches low outside start or zero data bits.
